uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  APB-slave UART transmitter: a PWDATA byte written at a transmitter address is sent
//  on tx_serial as an 8N1 frame, LSB first. Serial mirror of uart_receiver on the same
//  APB bus; PADDR[7]=1 selects the transmitter, PADDR[7]=0 belongs to the receiver.
//  PREADY stalls the APB write while a frame is in flight.
// PARAMETERS
//  CLKS_PER_BIT  87  PCLK cycles per serial bit (e.g. 10 MHz / 115200); legal range >= 2
// PORTS
//  PCLK         in   1  bus/system clock; all logic is on the rising edge
//  PRESETn      in   1  synchronous reset, active-low
//  PSEL         in   1  APB select
//  PENABLE      in   1  APB access phase
//  PWRITE       in   1  1 = write
//  PADDR        in   8  address; bit 7 = 1 decodes the transmitter, other bits ignored
//  PWDATA       in   8  byte to transmit
//  PREADY       out  1  1 = write can complete this cycle (state==IDLE)
//  tx_serial    out  1  serial line, idle high
//  tx_busy      out  1  1 while a frame is in progress (any state other than IDLE)
//  tx_done      out  1  one-cycle pulse at end of stop bit
// BEHAVIOUR
//  - Reset (PRESETn=0 at an edge): state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, PREADY=1,
//    bit counter, bit index and shift register cleared. Takes effect at the next edge,
//    including mid-frame. An aborted frame produces no tx_done.
//  - PREADY is combinational: PREADY = (state==IDLE). tx_busy = ~PREADY.
//  - Accept: edge with PSEL & PENABLE & PWRITE & PADDR[7] & PREADY latches PWDATA and
//    moves to START_BIT. Reads, PADDR[7]=0 and setup-phase cycles never change state.
//    A write issued while busy sees PREADY=0 (wait states) until IDLE, then completes.
//  - FSM (registered tx_serial); each state holds its bit for exactly CLKS_PER_BIT cycles.
//    Counter width = $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0:
//    IDLE -> START_BIT (line 0) -> DATA_BITS (line = data[idx], idx 0..7; idx+1 on each
//    counter wrap) -> [PARITY_BIT] -> STOP_BIT (line 1) -> IDLE.
//  - Latency: tx_serial falls on the accept edge +1 (first cycle after accept). Frame
//    length = 10*CLKS_PER_BIT cycles (11* with parity).
//  - tx_done=1 for exactly one cycle, the first IDLE cycle after STOP_BIT; PREADY=1 in
//    that same cycle. A pending write is accepted at the end of that cycle, giving exactly
//    one idle-high cycle between back-to-back frames.
//  - PWDATA changes after accept have no effect on the frame in progress.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY_BIT state inserted between DATA_BITS and STOP_BIT,
//    line = ^data (even parity), held CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT.
//  Undefined: no PARITY_BIT state, DATA_BITS -> STOP_BIT directly; plain 8N1.
// TESTING (bench uses CLKS_PER_BIT=4)
//  1. PRESETn=0 for 3 cycles -> tx_serial=1, PREADY=1, tx_busy=0, tx_done=0.
//  2. Write 0xA5 @PADDR=0x80 -> line 0,1,0,1,0,0,1,0,1,1, 4 cycles each (40 total);
//     tx_done pulses 1 cycle, 40 cycles after the accept edge.
//  3. Write 0x3C issued during 0xA5 frame -> PREADY=0 until IDLE, accepted in the tx_done
//     cycle, exactly 1 idle-high cycle, then 0x3C frame; two tx_done pulses total.
//  4. Write 0x55 @PADDR=0x05, and read @0x80 -> ignored: tx_serial=1, tx_busy=0 throughout.
//  5. PRESETn=0 during data bit 3 of 0xA5 -> next cycle tx_serial=1, PREADY=1, no
//     tx_done; a new write of 0x0F afterwards sends a clean full frame.
//  6. UART_TX_PARITY_EN: 0xA5 -> parity bit 0, 44-cycle frame; 0x07 -> parity bit 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: APB-slave UART transmitter sending each accepted byte as an 8N1 frame,
// LSB first. Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_serial_q, tx_serial_d;
  logic            tx_done_q, tx_done_d;
  logic            bit_end;
  logic            accept;

  // Only PADDR[7] takes part in the address decode.
  logic unused_paddr;
  assign unused_paddr = ^PADDR[6:0];

  assign PREADY    = (state_q == StIdle);
  assign tx_busy   = ~PREADY;
  assign tx_serial = tx_serial_q;
  assign tx_done   = tx_done_q;

  assign bit_end = (cnt_q == CntMax);
  assign accept  = PSEL & PENABLE & PWRITE & PADDR[7] & PREADY;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_serial_d = 1'b1;
        if (accept) begin
          state_d     = StStart;
          data_d      = PWDATA;
          cnt_d       = '0;
          idx_d       = 3'd0;
          tx_serial_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d     = StData;
          idx_d       = 3'd0;
          tx_serial_d = data_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d     = StParity;
            tx_serial_d = ^data_q;
`else
            state_d     = StStop;
            tx_serial_d = 1'b1;
`endif
          end else begin
            idx_d       = idx_q + 3'd1;
            tx_serial_d = data_q[idx_q + 3'd1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d     = StStop;
          tx_serial_d = 1'b1;
        end
      end
      StStop: begin
        // Done pulse lands in the first idle cycle, when PREADY is already high.
        if (bit_end) begin
          state_d   = StIdle;
          tx_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      data_q      <= 8'h00;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and randomized APB traffic checked every cycle against a
// frame-level reference model (bit vector plus cycle position).
module tb_uart_transmitter;

  localparam int unsigned Clks = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  localparam int unsigned FrameCycles = FrameBits * Clks;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PADDR = 8'h00;
  logic [7:0] PWDATA = 8'h00;
  logic       PREADY;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  uart_transmitter #(
    .CLKS_PER_BIT(Clks)
  ) u_dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected line levels of one frame, index = bit slot.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Bus inputs as seen by the DUT at the last rising edge.
  logic       s_rstn, s_psel, s_pen, s_pwr;
  logic [7:0] s_paddr, s_pwdata;
  logic       mon_en = 1'b0;

  initial begin
    forever begin
      @(posedge PCLK);
      s_rstn   = PRESETn;
      s_psel   = PSEL;
      s_pen    = PENABLE;
      s_pwr    = PWRITE;
      s_paddr  = PADDR;
      s_pwdata = PWDATA;
      if (!PRESETn) mon_en = 1'b1;
    end
  end

  // Reference model: one frame is a bit vector walked at Clks cycles per slot.
  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  int          m_pos = 0;
  logic [10:0] m_frame = '1;
  logic        exp_line;

  initial begin
    forever begin
      @(negedge PCLK);
      if (mon_en) begin
        if (!s_rstn) begin
          m_active = 1'b0;
          m_done   = 1'b0;
          m_pos    = 0;
        end else begin
          m_done = 1'b0;
          if (m_active) begin
            m_pos++;
            if (m_pos == FrameCycles) begin
              m_active = 1'b0;
              m_done   = 1'b1;
            end
          end else if (s_psel && s_pen && s_pwr && s_paddr[7]) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_frame  = build_frame(s_pwdata);
          end
        end
        exp_line = m_active ? m_frame[m_pos/Clks] : 1'b1;
        check_eq("tx_serial", tx_serial, exp_line);
        check_eq("PREADY", PREADY, !m_active);
        check_eq("tx_busy", tx_busy, m_active);
        check_eq("tx_done", tx_done, m_done);
        if (tx_done === 1'b1) done_cnt++;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the completing edge.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                          output int waits);
    PSEL    = 1'b1;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 200) begin
      @(negedge PCLK);
      waits++;
    end
    check_eq("apb_ready_within_bound", waits < 200, 1);
    @(negedge PCLK);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PWDATA  = 8'($urandom);
  endtask

  int w, d0, op, gap;

  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // Single frame.
    d0 = done_cnt;
    apb_xfer(1'b1, 8'h80, 8'hA5, w);
    check_eq("idle_write_no_wait", w, 0);
    repeat (FrameCycles + 4) @(negedge PCLK);
    check_eq("single_done_count", done_cnt - d0, 1);

    // Back-to-back: second write stalls until the done cycle.
    d0 = done_cnt;
    apb_xfer(1'b1, 8'h80, 8'hA5, w);
    apb_xfer(1'b1, 8'h80, 8'h3C, w);
    check_eq("b2b_stalled", w > 0, 1);
    repeat (FrameCycles + 4) @(negedge PCLK);
    check_eq("b2b_done_count", done_cnt - d0, 2);

    // Receiver-address write and transmitter read are ignored.
    d0 = done_cnt;
    apb_xfer(1'b1, 8'h05, 8'h55, w);
    apb_xfer(1'b0, 8'h80, 8'h00, w);
    repeat (20) @(negedge PCLK);
    check_eq("ignored_done_count", done_cnt - d0, 0);

    // Reset during data bit 3, then a clean frame.
    d0 = done_cnt;
    apb_xfer(1'b1, 8'h80, 8'hA5, w);
    repeat (18) @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (FrameCycles + 4) @(negedge PCLK);
    check_eq("abort_no_done", done_cnt - d0, 0);
    apb_xfer(1'b1, 8'h80, 8'h0F, w);
    repeat (FrameCycles + 4) @(negedge PCLK);
    check_eq("after_abort_done_count", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
    apb_xfer(1'b1, 8'h80, 8'h07, w);
    repeat (FrameCycles + 4) @(negedge PCLK);
`endif

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        apb_xfer(1'b1, {1'b1, 7'($urandom)}, 8'($urandom), w);
      end else if (op == 6) begin
        apb_xfer(1'b1, {1'b0, 7'($urandom)}, 8'($urandom), w);
      end else if (op == 7) begin
        apb_xfer(1'b0, 8'($urandom), 8'($urandom), w);
      end else begin
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
      end
      gap = int'($urandom_range(0, 50));
      for (int g = 0; g < gap; g++) begin
        @(negedge PCLK);
        PWDATA = 8'($urandom);
      end
    end
    repeat (FrameCycles + 4) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
